mc_ctrl: RTL and testbench

//  Multi-cycle MIPS control FSM. Decodes the instruction register and sequences the
//  IF/ID/EX/MA/WB steps. Drives EXTOp for the immediate extender, plus ALU, next-PC,

---
 rtl/mc_ctrl.sv | 160 ++++++++++++++++
 tb/tb_mc_ctrl.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS control FSM: decodes Op/Funct into an instruction class and
// sequences IF/ID/EX/MA/WB, driving PC/IR/GPR/DM strobes and datapath steering.
module mc_ctrl #(
  parameter bit HALT_ON_ILLEGAL = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] Op,
  input  logic [5:0] Funct,
  input  logic       Zero,
  input  logic       IMReady,
  input  logic       DMReady,
  output logic       PCWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic [1:0] EXTOp,
  output logic [2:0] ALUOp,
  output logic       ALUSrcB,
  output logic [1:0] NPCOp,
  output logic       GPRSel,
  output logic       WDSel,
  output logic       Illegal
);

  typedef enum logic [2:0] {
    S_IF   = 3'd0,
    S_ID   = 3'd1,
    S_EX   = 3'd2,
    S_MA   = 3'd3,
    S_WB   = 3'd4,
    S_HALT = 3'd5
  } state_t;

  typedef enum logic [3:0] {
    C_NOP, C_ADDU, C_SUBU, C_ORI, C_ADDI, C_LUI, C_LW, C_SW, C_BEQ, C_J, C_ILL
  } cls_t;

  state_t state, state_next;
  cls_t   cls_q, cls_dec, cls;

  function automatic cls_t decode(input logic [5:0] op, input logic [5:0] fn);
    cls_t c;
    case (op)
      6'b000000: begin
        case (fn)
          6'b100001: c = C_ADDU;
          6'b100011: c = C_SUBU;
          default:   c = C_ILL;
        endcase
      end
      6'b001101: c = C_ORI;
      6'b001000: c = C_ADDI;
      6'b001111: c = C_LUI;
      6'b100011: c = C_LW;
      6'b101011: c = C_SW;
      6'b000100: c = C_BEQ;
      6'b000010: c = C_J;
      default:   c = C_ILL;
    endcase
    return c;
  endfunction

  assign cls_dec = decode(Op, Funct);
  // In S_ID the class register is not yet loaded, so steer from the live decode.
  assign cls = (state == S_ID) ? cls_dec : cls_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IF;
      cls_q <= C_NOP;
    end else begin
      state <= state_next;
      if (state == S_ID) cls_q <= cls_dec;
    end
  end

  always_comb begin
    state_next = S_IF;
    case (state)
      S_IF: state_next = IMReady ? S_ID : S_IF;
      S_ID: begin
        if (cls_dec == C_J)        state_next = S_IF;
        else if (cls_dec == C_ILL) state_next = HALT_ON_ILLEGAL ? S_HALT : S_IF;
        else                       state_next = S_EX;
      end
      S_EX: begin
        if (cls == C_BEQ)                     state_next = S_IF;
        else if (cls == C_LW || cls == C_SW)  state_next = S_MA;
        else                                  state_next = S_WB;
      end
      S_MA: begin
        if (!DMReady)         state_next = S_MA;
        else if (cls == C_SW) state_next = S_IF;
        else                  state_next = S_WB;
      end
      S_WB:    state_next = S_IF;
      S_HALT:  state_next = S_HALT;
      default: state_next = S_IF;
    endcase
  end

  // Reset forces every output low in the same cycle, aborting any strobe.
  always_comb begin
    PCWrite  = 1'b0;
    IRWrite  = 1'b0;
    RegWrite = 1'b0;
    MemWrite = 1'b0;
    EXTOp    = 2'b00;
    ALUOp    = 3'b000;
    ALUSrcB  = 1'b0;
    NPCOp    = 2'b00;
    GPRSel   = 1'b0;
    WDSel    = 1'b0;
    Illegal  = 1'b0;
    if (!rst) begin
      if (state == S_ID || state == S_EX || state == S_MA || state == S_WB) begin
        case (cls)
          C_ADDI, C_LW, C_SW, C_BEQ: EXTOp = 2'b01;
          default:                   EXTOp = 2'b00;
        endcase
        case (cls)
          C_SUBU, C_BEQ: ALUOp = 3'b001;
          C_ORI:         ALUOp = 3'b010;
          C_LUI:         ALUOp = 3'b011;
          default:       ALUOp = 3'b000;
        endcase
        ALUSrcB = (cls == C_ORI) || (cls == C_ADDI) || (cls == C_LUI) ||
                  (cls == C_LW)  || (cls == C_SW);
      end
      case (state)
        S_IF: begin
          IRWrite = IMReady;
          PCWrite = IMReady;
        end
        S_ID: begin
          if (cls_dec == C_J) begin
            PCWrite = 1'b1;
            NPCOp   = 2'b10;
          end
          Illegal = (cls_dec == C_ILL);
        end
        S_EX: begin
          if (cls == C_BEQ) begin
            PCWrite = Zero;
            NPCOp   = 2'b01;
          end
        end
        S_MA: MemWrite = (cls == C_SW) && DMReady;
        S_WB: begin
          RegWrite = 1'b1;
          GPRSel   = (cls == C_ADDU) || (cls == C_SUBU);
          WDSel    = (cls == C_LW);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mc_ctrl.sv
// Randomized bench for mc_ctrl: two instances (skip / halt on illegal) run against
// a route-per-instruction reference model, checking every output every cycle.
module tb_mc_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] Op, Funct;
  logic       Zero, IMReady, DMReady;

  logic       pcw0, irw0, rw0, mw0, srcb0, gsel0, wsel0, ill0;
  logic [1:0] ext0, npc0;
  logic [2:0] alu0;
  logic       pcw1, irw1, rw1, mw1, srcb1, gsel1, wsel1, ill1;
  logic [1:0] ext1, npc1;
  logic [2:0] alu1;

  always #5 clk = ~clk;

  mc_ctrl #(.HALT_ON_ILLEGAL(1'b0)) u_skip (
    .clk(clk), .rst(rst), .Op(Op), .Funct(Funct), .Zero(Zero),
    .IMReady(IMReady), .DMReady(DMReady),
    .PCWrite(pcw0), .IRWrite(irw0), .RegWrite(rw0), .MemWrite(mw0),
    .EXTOp(ext0), .ALUOp(alu0), .ALUSrcB(srcb0), .NPCOp(npc0),
    .GPRSel(gsel0), .WDSel(wsel0), .Illegal(ill0)
  );

  mc_ctrl #(.HALT_ON_ILLEGAL(1'b1)) u_halt (
    .clk(clk), .rst(rst), .Op(Op), .Funct(Funct), .Zero(Zero),
    .IMReady(IMReady), .DMReady(DMReady),
    .PCWrite(pcw1), .IRWrite(irw1), .RegWrite(rw1), .MemWrite(mw1),
    .EXTOp(ext1), .ALUOp(alu1), .ALUSrcB(srcb1), .NPCOp(npc1),
    .GPRSel(gsel1), .WDSel(wsel1), .Illegal(ill1)
  );

  // Phases and instruction kinds of the reference model.
  localparam int P_IF = 0, P_ID = 1, P_EX = 2, P_MA = 3, P_WB = 4, P_HALT = 5;
  localparam int K_ADDU = 0, K_SUBU = 1, K_ORI = 2, K_ADDI = 3, K_LUI = 4, K_LW = 5,
                 K_SW = 6, K_BEQ = 7, K_J = 8, K_ILL = 9;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [5:0] t_op [12];
  logic [5:0] t_fn [12];
  int         t_k  [12];

  task automatic check_eq(input string tag, input logic [14:0] act, input logic [14:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%h expected=%h", tag, cyc, act, exp);
    end
  endtask

  // Ordered list of phases an instruction walks through; waits repeat IF/MA.
  function automatic int route_len(input int k);
    case (k)
      K_J, K_ILL: return 2;
      K_BEQ:      return 3;
      K_LW:       return 5;
      default:    return 4;
    endcase
  endfunction

  function automatic int route_at(input int k, input int i);
    if (i == 3) return (k == K_LW || k == K_SW) ? P_MA : P_WB;
    if (i == 4) return P_WB;
    return i;
  endfunction

  // Output vector: {PCWrite,IRWrite,RegWrite,MemWrite,EXTOp,ALUOp,ALUSrcB,NPCOp,GPRSel,WDSel,Illegal}
  function automatic logic [14:0] expect_out(input int ph, input int k, input logic im,
                                             input logic dm, input logic z);
    logic pcw, irw, rw, mw, srcb, gsel, wsel, ill;
    logic [1:0] ext, npc;
    logic [2:0] alu;
    {pcw, irw, rw, mw, srcb, gsel, wsel, ill} = '0;
    ext = 2'b00; npc = 2'b00; alu = 3'b000;
    if (ph != P_IF && ph != P_HALT) begin
      ext  = (k == K_ADDI || k == K_LW || k == K_SW || k == K_BEQ) ? 2'b01 : 2'b00;
      alu  = (k == K_SUBU || k == K_BEQ) ? 3'b001 :
             (k == K_ORI) ? 3'b010 : (k == K_LUI) ? 3'b011 : 3'b000;
      srcb = (k == K_ORI || k == K_ADDI || k == K_LUI || k == K_LW || k == K_SW);
    end
    if (ph == P_IF) begin irw = im; pcw = im; end
    if (ph == P_ID && k == K_J) begin pcw = 1'b1; npc = 2'b10; end
    if (ph == P_ID && k == K_ILL) ill = 1'b1;
    if (ph == P_EX && k == K_BEQ) begin pcw = z; npc = 2'b01; end
    if (ph == P_MA && k == K_SW) mw = dm;
    if (ph == P_WB) begin
      rw = 1'b1;
      gsel = (k == K_ADDU || k == K_SUBU);
      wsel = (k == K_LW);
    end
    return {pcw, irw, rw, mw, ext, alu, srcb, npc, gsel, wsel, ill};
  endfunction

  initial begin
    int idx, kind, step, ph;
    bit halted;
    logic [14:0] e0, e1;

    t_op[0]  = 6'b000000; t_fn[0]  = 6'b100001; t_k[0]  = K_ADDU;
    t_op[1]  = 6'b000000; t_fn[1]  = 6'b100011; t_k[1]  = K_SUBU;
    t_op[2]  = 6'b001101; t_fn[2]  = 6'b111111; t_k[2]  = K_ORI;
    t_op[3]  = 6'b001000; t_fn[3]  = 6'b000000; t_k[3]  = K_ADDI;
    t_op[4]  = 6'b001111; t_fn[4]  = 6'b100001; t_k[4]  = K_LUI;
    t_op[5]  = 6'b100011; t_fn[5]  = 6'b000000; t_k[5]  = K_LW;
    t_op[6]  = 6'b101011; t_fn[6]  = 6'b000000; t_k[6]  = K_SW;
    t_op[7]  = 6'b000100; t_fn[7]  = 6'b000000; t_k[7]  = K_BEQ;
    t_op[8]  = 6'b000010; t_fn[8]  = 6'b000000; t_k[8]  = K_J;
    t_op[9]  = 6'b111111; t_fn[9]  = 6'b000000; t_k[9]  = K_ILL;
    t_op[10] = 6'b000000; t_fn[10] = 6'b100000; t_k[10] = K_ILL;
    t_op[11] = 6'b000101; t_fn[11] = 6'b000000; t_k[11] = K_ILL;

    rst = 1'b1; Op = '0; Funct = '0; Zero = 1'b0; IMReady = 1'b1; DMReady = 1'b1;
    kind = K_ADDU; step = 0; halted = 1'b0;

    for (int n = 0; n < 5000; n++) begin
      @(negedge clk);
      cyc = n;
      rst = (n < 2) || ($urandom_range(0, 99) < 3);
      ph = route_at(kind, step);
      if (ph == P_IF) begin
        idx = $urandom_range(0, 11);
        kind = t_k[idx];
        Op = t_op[idx];
        Funct = (t_op[idx] == 6'b000000) ? t_fn[idx] : 6'($urandom);
      end
      IMReady = ($urandom_range(0, 3) != 0);
      DMReady = ($urandom_range(0, 2) != 0);
      Zero    = $urandom_range(0, 1) == 1;
      #1;
      e0 = rst ? 15'd0 : expect_out(ph, kind, IMReady, DMReady, Zero);
      e1 = halted ? 15'd0 : e0;
      check_eq("skip_inst", {pcw0, irw0, rw0, mw0, ext0, alu0, srcb0, npc0, gsel0, wsel0, ill0}, e0);
      check_eq("halt_inst", {pcw1, irw1, rw1, mw1, ext1, alu1, srcb1, npc1, gsel1, wsel1, ill1}, e1);

      // Advance the model to the phase of the next cycle.
      if (rst) begin
        step = 0;
        halted = 1'b0;
      end else begin
        if (ph == P_ID && kind == K_ILL) halted = 1'b1;
        if (!((ph == P_IF && !IMReady) || (ph == P_MA && !DMReady))) begin
          step = step + 1;
          if (step >= route_len(kind)) step = 0;
        end
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
